// File: rtl/code_converter_stream_if.sv
// Handshake bundle for code_converter_stream. The slave side is the converter
// and the master side is the source/sink pair.
interface code_converter_stream_if #(
   parameter int LANES = 1
);
   logic [1:0]         mode;
   logic               in_valid;
   logic               in_ready;
   logic [4*LANES-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [4*LANES-1:0] out_data;
   logic [LANES-1:0]   out_err;

   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/code_converter_stream.sv
// Multi-lane 4-bit code converter (Gray, inverse Gray, excess-3, pass-through).
// Converted words are queued in an output FIFO. A saturating counter records words that contain bad BCD digits.
module code_converter_stream #(
   parameter int LANES      = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   code_converter_stream_if.slave            bus,
   input  logic                              clr_err,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic [ERR_CNT_W-1:0]              err_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int DW    = 4 * LANES;

   logic [DW-1:0]    data_mem [FIFO_DEPTH];
   logic [LANES-1:0] err_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [DW-1:0]    conv_data;
   logic [LANES-1:0] conv_err;
   logic             push;
   logic             pop;
   logic             out_valid_int;

   // Result is {err, digit}; err can only be set in excess-3 mode.
   function automatic logic [4:0] conv_digit(input logic [1:0] m, input logic [3:0] d);
      logic [3:0] b;
      logic [4:0] r;
      r = '0;
      b = '0;
      case (m)
         2'd0: r = {1'b0, d[3], d[3] ^ d[2], d[2] ^ d[1], d[1] ^ d[0]};
         2'd1: begin
            b[3] = d[3];
            b[2] = b[3] ^ d[2];
            b[1] = b[2] ^ d[1];
            b[0] = b[1] ^ d[0];
            r    = {1'b0, b};
         end
         2'd2: begin
            if (d <= 4'd9) r = {1'b0, d + 4'd3};
            else           r = {1'b1, 4'h0};
         end
         default: r = {1'b0, d};
      endcase
      return r;
   endfunction

   always_comb begin
      conv_data = '0;
      conv_err  = '0;
      for (int i = 0; i < LANES; i++) begin
         {conv_err[i], conv_data[4*i +: 4]} = conv_digit(bus.mode, bus.in_data[4*i +: 4]);
      end
   end

   // Ready depends only on stored count, so a same-cycle pop never frees a slot.
   assign bus.in_ready  = !reset && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign out_valid_int = (fifo_count != '0);
   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = out_valid_int ? data_mem[rd_ptr] : '0;
   assign bus.out_err   = out_valid_int ? err_mem[rd_ptr]  : '0;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = out_valid_int && bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_mem[i] <= '0;
            err_mem[i]  <= '0;
         end
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= conv_data;
            err_mem[wr_ptr]  <= conv_err;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= '0;
      end else if (push && (|conv_err) && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_code_converter_stream.sv
// Directed bench for code_converter_stream (LANES=2, FIFO_DEPTH=4, ERR_CNT_W=2).
// The stimulus pushes hand-computed results into a scoreboard queue, and a negedge monitor pops and compares them.
module tb_code_converter_stream;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] e;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       clr_err;
   logic [2:0] fifo_count;
   logic [1:0] err_count;

   int   total;
   int   bad;
   exp_t sb[$];

   code_converter_stream_if #(.LANES(2)) bus ();

   code_converter_stream #(
      .LANES(2),
      .FIFO_DEPTH(4),
      .ERR_CNT_W(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .clr_err(clr_err),
      .fifo_count(fifo_count),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a handshake seen at the negedge completes on the next posedge.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (!bus.out_valid) begin
            check("idle_zero", {22'd0, bus.out_data, bus.out_err}, 32'd0);
         end else if (bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("out_data", {24'd0, bus.out_data}, {24'd0, e.d});
               check("out_err", {30'd0, bus.out_err}, {30'd0, e.e});
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [1:0] m, input logic [7:0] d,
                       input logic [7:0] ed, input logic [1:0] ee);
      bit done;
      done        = 1'b0;
      bus.mode    = m;
      bus.in_data = d;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         done = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (done) sb.push_back('{d: ed, e: ee});
      else check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_empty();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (sb.size() == 0 && fifo_count == 3'd0) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("drain", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      clr_err      = 1'b0;
      bus.mode     = 2'd0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_count", {29'd0, fifo_count}, 32'd0);
      check("rst_err_count", {30'd0, err_count}, 32'd0);
      check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

      // Gray and inverse Gray, latency 1
      bus.out_ready = 1'b1;
      send(2'd0, 8'h5A, 8'h7F, 2'b00);
      check("latency_valid", {31'd0, bus.out_valid}, 32'd1);
      send(2'd1, 8'h7F, 8'h5A, 2'b00);
      send(2'd0, 8'h3F, 8'h28, 2'b00);
      send(2'd1, 8'h28, 8'h3F, 2'b00);
      send(2'd3, 8'hE5, 8'hE5, 2'b00);

      // Excess-3 and error counting with saturation at 3
      send(2'd2, 8'h9C, 8'hC0, 2'b01);
      check("err_cnt_1", {30'd0, err_count}, 32'd1);
      send(2'd2, 8'h47, 8'h7A, 2'b00);
      check("err_cnt_hold", {30'd0, err_count}, 32'd1);
      send(2'd2, 8'h0F, 8'h30, 2'b01);
      send(2'd2, 8'hA5, 8'h08, 2'b10);
      send(2'd2, 8'hBB, 8'h00, 2'b11);
      send(2'd2, 8'h9C, 8'hC0, 2'b01);
      check("err_cnt_sat", {30'd0, err_count}, 32'd3);
      clr_err = 1'b1;
      send(2'd2, 8'h9C, 8'hC0, 2'b01);
      clr_err = 1'b0;
      check("err_clr_prio", {30'd0, err_count}, 32'd0);
      send(2'd2, 8'hD2, 8'h05, 2'b10);
      check("err_after_clr", {30'd0, err_count}, 32'd1);
      wait_empty();

      // Full FIFO and backpressure
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(2'd3, 8'(i), 8'(i), 2'b00);
      check("full_count", {29'd0, fifo_count}, 32'd4);
      check("full_ready", {31'd0, bus.in_ready}, 32'd0);
      fork
         send(2'd3, 8'h05, 8'h05, 2'b00);
         begin
            repeat (3) @(posedge clk);
            #1;
            check("full_held", {29'd0, fifo_count}, 32'd4);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("full_pop_no_push", {29'd0, fifo_count}, 32'd3);
         end
      join
      wait_empty();

      // Simultaneous push and pop at count 2
      bus.out_ready = 1'b0;
      send(2'd3, 8'h11, 8'h11, 2'b00);
      send(2'd3, 8'h22, 8'h22, 2'b00);
      check("pp_count_pre", {29'd0, fifo_count}, 32'd2);
      bus.mode      = 2'd3;
      bus.in_data   = 8'h33;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      sb.push_back('{d: 8'h33, e: 2'b00});
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("pp_count_post", {29'd0, fifo_count}, 32'd2);
      bus.out_ready = 1'b1;
      wait_empty();

      // Pointer wrap over 10 words
      for (int i = 0; i < 10; i++) send(2'd3, 8'(i * 19 + 1), 8'(i * 19 + 1), 2'b00);
      wait_empty();

      // Reset mid-stream
      bus.out_ready = 1'b0;
      send(2'd3, 8'hA1, 8'hA1, 2'b00);
      send(2'd3, 8'hB2, 8'hB2, 2'b00);
      send(2'd3, 8'hC3, 8'hC3, 2'b00);
      check("mid_count", {29'd0, fifo_count}, 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_data", {24'd0, bus.out_data}, 32'd0);
      check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
      sb.delete();
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      send(2'd0, 8'h5A, 8'h7F, 2'b00);
      check("post_rst_latency", {31'd0, bus.out_valid}, 32'd1);
      wait_empty();

      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/code_converter_stream.md
Name: code_converter_stream

Overview:
Parametrised multi-lane 4-bit code converter, the streaming successor to the team's single-word ready-strobed encoder. Each accepted input word holds LANES 4-bit digits. Every digit is converted in the mode selected at acceptance. Results are queued in an output FIFO with valid/ready handshakes on both sides. The block sits between a digit source (keypad/ALU front end) and a display or transmit stage. It also flags invalid digits per lane and keeps a saturating error count.

Parameters:
LANES, 1, number of 4-bit digits per word (>=1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
ERR_CNT_W, 8, width of error counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, asynchronous, active-high
mode  input  2  conversion mode, sampled with each accepted word
in_valid  input  1  input word present
in_ready  output  1  block can accept word
in_data  input  4*LANES  digits; lane i = bits [4i+3:4i]
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  4*LANES  converted digits, same lane layout
out_err  output  LANES  per-lane invalid-digit flag for head word
fifo_count  output  clog2(FIFO_DEPTH+1)  words stored
err_count  output  ERR_CNT_W  accepted words with >=1 invalid lane
clr_err  input  1  synchronous clear of err_count

Behaviour:
- Reset (async assert, sync to clk on release): FIFO pointers and count = 0, out_valid=0, out_data=0, out_err=0, err_count=0, in_ready=0 while reset is high. Reset mid-operation discards all queued words immediately.
- Accept: push occurs when in_valid & in_ready on a rising edge. in_ready = (fifo_count < FIFO_DEPTH), from registered state only. A pop in the same cycle does not free space for a push when full.
- Conversion (combinational on in_data, per lane, written into FIFO with mode's result):
  - mode 0, binary->Gray: g3=b3, g2=b3^b2, g1=b2^b1, g0=b1^b0.
  - mode 1, Gray->binary: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
  - mode 2, BCD->excess-3: digit 0..9 -> digit+3 (4-bit); digit 10..15 -> 4'h0 with lane err=1.
  - mode 3: pass-through.
  - out_err is 0 in all modes except mode 2.
- Mode is captured per word; changing mode never alters words already queued.
- Latency: a word accepted at edge k appears at out_valid/out_data after edge k (1 cycle, no bypass), if the FIFO was empty.
- Pop occurs when out_valid & out_ready. Order is strictly FIFO.
- When out_valid=0, out_data and out_err are forced to 0.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- err_count:
  - +1 per accepted word with any out_err lane set (not per lane).
  - Saturates at all-ones.
  - clr_err has priority over an increment in the same cycle (result 0).
- No other state. No X propagation: every output is defined from reset onward.

Test Plan:
- Gray (LANES=2): mode=0, in_data=8'h5A -> one cycle later out_valid=1, out_data=8'h7F, out_err=2'b00; mode=1, in_data=8'h7F -> out_data=8'h5A.
- Excess-3 with error (LANES=2): mode=2, in_data=8'h9C -> out_data=8'hC0, out_err=2'b01, err_count=1; in_data=8'h47 -> out_data=8'h7A, out_err=0, err_count stays 1.
- Full/backpressure (FIFO_DEPTH=4): out_ready=0, push 5 words 1..5 in mode 3 -> in_ready=0 after 4th push, fifo_count=4, word 5 held; raise out_ready -> outputs 1,2,3,4 in order, then word 5 accepted.
- Simultaneous push/pop with count=2 -> count stays 2; pointer wrap over 10 words shows no loss or reorder.
- Saturation (ERR_CNT_W=2): 5 error words -> err_count=3; clr_err asserted on the same edge as an error word -> err_count=0.
- Reset mid-stream: 3 words queued, reset pulsed between edges -> out_valid=0, out_data=0, fifo_count=0 immediately; after release in_ready=1 and the next word has latency 1.
